mem_loader: RTL and testbench
=============================

# mem_loader

Debug-side write engine for the 2048×32 instruction/data memory. Accepts a byte stream from the debug link (valid/ready), packs bytes into 32-bit words, buffers them in 8-word blocks, and writes each block into the memory. Each block takes four paired write strobes, because the memory's second port always targets word address + 4. The block owns the memory write/address/data pins while the debug unit is loading; outside a session, the write strobe is idle-high and the PC only reads.

## Interface
- ADDR_W, 11, word address width of the memory
- DATA_W, 32, memory word width
- BLK_CNT_W, 9, width of the block-count input (max 256 blocks = 2048 words)

- Clk  in  1  single clock; all state updates on rising edge
- Rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a session (sampled in IDLE only)
- base_addr  in  ADDR_W  first word address; bits [2:0] ignored (forced 0)
- num_blocks  in  BLK_CNT_W  number of 8-word blocks to load; sampled with start
- byte_data  in  8  stream byte
- byte_valid  in  1  byte_data valid
- byte_ready  out  1  loader accepts byte (transfer = valid & ready)
- mem_address  out  ADDR_W  port-1 word address (port 2 writes mem_address+4)
- mem_datain1  out  DATA_W  word for mem_address
- mem_datain2  out  DATA_W  word for mem_address+4
- mem_wr  out  1  memory write strobe, active-low (0 = write both ports)
- mem_enable_half  out  1  held 0 (memory clock enabled)
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at session end
- error  out  1  one-cycle pulse: start received while busy

## Operation
- States: IDLE, FILL, WRITE, DONE.
- **IDLE.** byte_ready=0, mem_wr=1.
  - start with num_blocks≠0: latch base_addr & ~7 as blk_base and num_blocks as remaining; go to FILL.
  - start with num_blocks=0: go straight to DONE.
- **FILL.** byte_ready=1.
  - Bytes are packed little-endian: the 1st byte goes to [7:0], the 4th to [31:24].
  - Completed words are stored in buffer slot w = 0..7.
  - After the 32nd byte, byte_ready drops and the state goes to WRITE with pair index k=0.
- **WRITE.** Lasts 4 cycles, k = 0..3. Each cycle drives:
  - mem_wr=0
  - mem_address = blk_base+k
  - mem_datain1 = buf[k], mem_datain2 = buf[k+4]
- **After k=3.**
  - blk_base += 8; remaining -= 1.
  - remaining≠0: return to FILL.
  - remaining=0: go to DONE.
- **DONE.** One cycle with done=1, then IDLE.
- busy=1 in FILL, WRITE and DONE.
- Address arithmetic is modulo 2^ADDR_W. blk_base+8 past 2047 wraps to 0, and the mem_address+4 target wraps inside the memory the same way.
- start in any non-IDLE state is ignored; error pulses for 1 cycle; the session continues unaffected.
- byte_valid with byte_ready=0 is ignored; no bytes are dropped or duplicated.
- Reset (any state, async):
  - state → IDLE
  - byte_ready=0, mem_wr=1, mem_enable_half=0, busy=0, done=0, error=0
  - mem_address=0, mem_datain1=0, mem_datain2=0
  - byte/word counters and buffer pointer cleared
  - A partially filled block is discarded; no write strobe is emitted.

## Timing
- All outputs are registered. mem_address and both data buses are stable for the whole cycle in which mem_wr=0.
- mem_wr returns to 1 on the first cycle after each write burst.
- Last byte of a block accepted at edge t:
  - mem_wr=0 in cycles t+1..t+4.
  - byte_ready=1 again at t+5 if blocks remain.
  - Otherwise done=1 at t+5, IDLE at t+6.
- start accepted at edge t: busy=1 and byte_ready=1 from t+1.
- With num_blocks=0: done=1 at t+1.
- Throughput: 1 byte/cycle in FILL. A block costs 32 + 4 cycles at full input rate.

## Structure
- Package mem_loader_pkg holds:
  - state enum (IDLE, FILL, WRITE, DONE)
  - BLOCK_WORDS=8, PAIR_OFFSET=4, BYTES_PER_WORD=4
  - ADDR_W and DATA_W defaults
- Sub-module word_packer:
  - byte valid/ready in; 32-bit word plus word_valid pulse out
  - 2-bit byte counter; cleared by reset and by a flush input
- mem_loader contains the FSM, the 8×32 buffer, the block/pair counters and the output registers.

## Test plan
- **Reset values.** Assert Rst_n=0 mid-FILL after 13 bytes → outputs immediately at reset values, mem_wr=1. Release, start base=0x010, 1 block, bytes 0x00..0x1F → writes (0x010, 0x03020100, 0x13121110) … (0x013, 0x0F0E0D0C, 0x1F1E1D1C). No stale bytes appear.
- **Block pairing.** start base=0x123 (aligned to 0x120), 2 blocks, incrementing bytes. Expect:
  - 8 write strobes at addresses 0x120..0x123 then 0x128..0x12B
  - datain2 always equals the word for address+4
  - done pulses once, 1 cycle after the last strobe
- **Wrap-around.** base=0x7F8, 2 blocks → second block writes at 0x000..0x003; busy stays high throughout.
- **Back-pressure and gaps.** Randomly deassert byte_valid while holding byte_valid=1 during WRITE → byte_ready=0 for exactly 4 cycles per block; the byte count seen by the memory equals the byte count sent.
- **Zero and illegal start.** num_blocks=0 → done at t+1 with no mem_wr=0 cycle. start during WRITE → error pulse of 1 cycle; address sequence unchanged.

Source files
------------

// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the debug-side memory loader.
package mem_loader_pkg;

  // Default memory geometry: 2048 words of 32 bits.
  localparam int MEM_ADDR_W    = 11;
  localparam int MEM_DATA_W    = 32;
  localparam int MEM_BLK_CNT_W = 9;

  // A block is 8 words, written as 4 pairs (k, k+4).
  localparam int BLOCK_WORDS    = 8;
  localparam int PAIR_OFFSET    = 4;
  localparam int BYTES_PER_WORD = 4;

  // Session state machine.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_loader_word_packer.sv
// Packs an accepted byte stream little-endian into 32-bit words. The word
// output is combinational: it is valid in the same cycle the fourth byte
// is transferred, so the caller can store it on that same edge.
module word_packer
  import mem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  input  logic        byte_ready_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] lo_q, lo_d;
  logic        accept;

  assign accept = byte_valid_i & byte_ready_i;

  // Byte position counter and the three low bytes collected so far.
  always_comb begin
    cnt_d = cnt_q;
    lo_d  = lo_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else if (accept) begin
      cnt_d = cnt_q + 2'd1;
      case (cnt_q)
        2'd0:    lo_d[7:0]   = byte_data_i;
        2'd1:    lo_d[15:8]  = byte_data_i;
        2'd2:    lo_d[23:16] = byte_data_i;
        default: lo_d        = lo_q;
      endcase
    end
  end

  // Counter/holding register update; reset discards any partial word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 2'd0;
      lo_q  <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
      lo_q  <= lo_d;
    end
  end

  assign word_o       = {byte_data_i, lo_q};
  assign word_valid_o = accept & ~flush_i & (cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_loader.sv
// Debug memory loader: collects 32 bytes into an 8-word block buffer and
// writes it to the dual-port memory as 4 paired strobes (addr, addr+4).
//
// Byte handshake: a byte transfers on a rising edge where byte_valid and
// byte_ready are both 1; byte_ready is registered and only high in FILL,
// byte_valid while byte_ready=0 is ignored.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W    = MEM_ADDR_W,
  parameter int DATA_W    = MEM_DATA_W,
  parameter int BLK_CNT_W = MEM_BLK_CNT_W
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [BLK_CNT_W-1:0] num_blocks,
  input  logic [7:0]           byte_data,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [DATA_W-1:0]    mem_datain1,
  output logic [DATA_W-1:0]    mem_datain2,
  output logic                 mem_wr,
  output logic                 mem_enable_half,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           dbg_state
);

  state_e               state_q, state_d;
  logic [2:0]           word_idx_q, word_idx_d;
  logic [1:0]           pair_q, pair_d;
  logic [ADDR_W-1:0]    blk_base_q, blk_base_d;
  logic [BLK_CNT_W-1:0] remaining_q, remaining_d;
  logic [DATA_W-1:0]    blk_buf_q [BLOCK_WORDS];

  logic                 byte_ready_q, byte_ready_d;
  logic                 mem_wr_q, mem_wr_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [ADDR_W-1:0]    mem_address_q, mem_address_d;
  logic [DATA_W-1:0]    datain1_q, datain1_d;
  logic [DATA_W-1:0]    datain2_q, datain2_d;

  logic [31:0]          word;
  logic                 word_valid;
  logic                 unused_base_lsbs;

  // Block alignment drops the low three address bits.
  assign unused_base_lsbs = ^base_addr[2:0];

  word_packer u_packer (
    .clk_i       (Clk),
    .rst_ni      (Rst_n),
    .flush_i     (state_q == S_IDLE),
    .byte_data_i (byte_data),
    .byte_valid_i(byte_valid),
    .byte_ready_i(byte_ready_q),
    .word_o      (word),
    .word_valid_o(word_valid)
  );

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (num_blocks != '0) ? S_FILL : S_DONE;
      end
      S_FILL: begin
        if (word_valid && (word_idx_q == 3'(BLOCK_WORDS - 1))) state_d = S_WRITE;
      end
      S_WRITE: begin
        if (pair_q == 2'd3) begin
          state_d = (remaining_q == BLK_CNT_W'(1)) ? S_DONE : S_FILL;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Block/pair counters: pair_d is the pair driven in the next cycle.
  always_comb begin
    word_idx_d  = word_idx_q;
    pair_d      = 2'd0;
    blk_base_d  = blk_base_q;
    remaining_d = remaining_q;
    if (state_q == S_IDLE) begin
      word_idx_d = 3'd0;
      if (start && (num_blocks != '0)) begin
        blk_base_d  = {base_addr[ADDR_W-1:3], 3'b000};
        remaining_d = num_blocks;
      end
    end else if (word_valid) begin
      word_idx_d = word_idx_q + 3'd1;
    end
    if (state_q == S_WRITE) begin
      pair_d = pair_q + 2'd1;
      if (pair_q == 2'd3) begin
        blk_base_d  = blk_base_q + ADDR_W'(BLOCK_WORDS);
        remaining_d = remaining_q - BLK_CNT_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      word_idx_q  <= 3'd0;
      pair_q      <= 2'd0;
      blk_base_q  <= '0;
      remaining_q <= '0;
    end else begin
      word_idx_q  <= word_idx_d;
      pair_q      <= pair_d;
      blk_base_q  <= blk_base_d;
      remaining_q <= remaining_d;
    end
  end

  // Block buffer: completed words land in their slot on the transfer edge.
  always_ff @(posedge Clk) begin
    if (word_valid) blk_buf_q[word_idx_q] <= word;
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    byte_ready_d  = (state_d == S_FILL);
    mem_wr_d      = (state_d != S_WRITE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    error_d       = start && (state_q != S_IDLE);
    mem_address_d = mem_address_q;
    datain1_d     = datain1_q;
    datain2_d     = datain2_q;
    if (state_d == S_WRITE) begin
      mem_address_d = blk_base_q + ADDR_W'(pair_d);
      datain1_d     = blk_buf_q[{1'b0, pair_d}];
      datain2_d     = blk_buf_q[{1'b0, pair_d} + 3'(PAIR_OFFSET)];
    end
  end

  // Output registers; the write strobe idles high.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      byte_ready_q  <= 1'b0;
      mem_wr_q      <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      mem_address_q <= '0;
      datain1_q     <= '0;
      datain2_q     <= '0;
    end else begin
      byte_ready_q  <= byte_ready_d;
      mem_wr_q      <= mem_wr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      mem_address_q <= mem_address_d;
      datain1_q     <= datain1_d;
      datain2_q     <= datain2_d;
    end
  end

  assign byte_ready      = byte_ready_q;
  assign mem_wr          = mem_wr_q;
  assign mem_enable_half = 1'b0;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign mem_address     = mem_address_q;
  assign mem_datain1     = datain1_q;
  assign mem_datain2     = datain2_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: reset, pairing, wrap, back-pressure,
// zero-length and illegal-start sessions.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int AW = 11;
  localparam int DW = 32;
  localparam int W  = AW + 2 * DW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [8:0]    num_blocks = '0;
  logic [7:0]    byte_data = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready, mem_wr, mem_enable_half, busy, done, error;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_datain1, mem_datain2;
  logic [1:0]    dbg_state;

  mem_loader dut (
    .Clk(clk), .Rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_blocks(num_blocks), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_address(mem_address), .mem_datain1(mem_datain1),
    .mem_datain2(mem_datain2), .mem_wr(mem_wr), .mem_enable_half(mem_enable_half),
    .busy(busy), .done(done), .error(error), .dbg_state(dbg_state)
  );

  // Scoreboard state
  int check_cnt = 0;
  int pass_cnt  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int  cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
  int  err_cnt = 0, stall_cnt = 0, overlap_cnt = 0, busy_gap = 0;
  bit  in_sess = 1'b0;

  // Memory-side monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (mem_wr === 1'b0) begin
        got_q.push_back({mem_address, mem_datain1, mem_datain2});
        last_wr_cyc = cyc;
        if (byte_ready === 1'b1) overlap_cnt++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (error === 1'b1) err_cnt++;
      if (busy === 1'b1 && byte_ready === 1'b0 && done === 1'b0) stall_cnt++;
      if (in_sess && busy !== 1'b1) busy_gap++;
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    check_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    done_cnt = 0; err_cnt = 0; stall_cnt = 0; overlap_cnt = 0; busy_gap = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  // Driver tasks
  task automatic do_start(input logic [AW-1:0] base, input logic [8:0] n);
    start = 1'b1;
    base_addr = base;
    num_blocks = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_stream(input int first, input int n, input bit gaps);
    int sent = 0;
    int budget = 0;
    bit accept;
    while (sent < n && budget < 5000) begin
      byte_data = 8'(first + sent);
      if (!gaps || byte_ready !== 1'b1) byte_valid = 1'b1;
      else byte_valid = ($urandom_range(0, 3) != 0);
      accept = byte_valid && (byte_ready === 1'b1);
      @(negedge clk);
      budget++;
      if (accept) sent++;
    end
    byte_valid = 1'b0;
    chk("bytes_sent", 64'(sent), 64'(n));
  endtask

  task automatic wait_done(input int max);
    int i = 0;
    while (done !== 1'b1 && i < max) begin
      @(negedge clk);
      i++;
    end
    chk1("done_seen", done, 1'b1);
  endtask

  function automatic logic [31:0] word_of(input int s, input int j);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(s + 4 * j);
    b1 = 8'(s + 4 * j + 1);
    b2 = 8'(s + 4 * j + 2);
    b3 = 8'(s + 4 * j + 3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic push_block(input logic [AW-1:0] base, input int s);
    logic [AW-1:0] a;
    for (int k = 0; k < 4; k++) begin
      a = base + AW'(k);
      exp_q.push_back({a, word_of(s, k), word_of(s, k + 4)});
    end
  endtask

  task automatic compare_writes(input string tag);
    logic [W-1:0] g, e;
    int n;
    chk({tag, "_nwr"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      g = got_q[i];
      e = exp_q[i];
      chk({tag, "_addr"}, 64'(g[W-1:2*DW]), 64'(e[W-1:2*DW]));
      chk({tag, "_d1"}, 64'(g[2*DW-1:DW]), 64'(e[2*DW-1:DW]));
      chk({tag, "_d2"}, 64'(g[DW-1:0]), 64'(e[DW-1:0]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk1("rst_ready", byte_ready, 1'b0);
    chk1("rst_wr", mem_wr, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", error, 1'b0);
    chk1("rst_half", mem_enable_half, 1'b0);
    chk("rst_addr", 64'(mem_address), 64'h0);
    chk("rst_state", 64'(dbg_state), 64'(S_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Reset mid-FILL after 13 bytes
    clear_mon();
    do_start(11'h200, 9'd1);
    chk1("start_busy", busy, 1'b1);
    chk1("start_ready", byte_ready, 1'b1);
    send_stream(8'hA0, 13, 1'b0);
    rst_n = 1'b0;
    #1;
    chk1("arst_ready", byte_ready, 1'b0);
    chk1("arst_wr", mem_wr, 1'b1);
    chk1("arst_busy", busy, 1'b0);
    chk("arst_addr", 64'(mem_address), 64'h0);
    chk("arst_d1", 64'(mem_datain1), 64'h0);
    chk("arst_d2", 64'(mem_datain2), 64'h0);
    chk("arst_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_nowr", 64'(got_q.size()), 64'h0);

    // Clean single block at 0x010 with bytes 0x00..0x1F
    clear_mon();
    push_block(11'h010, 0);
    do_start(11'h010, 9'd1);
    send_stream(0, 32, 1'b0);
    chk("blk0_d1", 64'(mem_datain1), 64'h03020100);
    chk("blk0_d2", 64'(mem_datain2), 64'h13121110);
    for (int k = 0; k < 4; k++) begin
      chk1("blk0_wr", mem_wr, 1'b0);
      chk("blk0_addr", 64'(mem_address), 64'(11'h010 + k));
      @(negedge clk);
    end
    chk1("blk0_done", done, 1'b1);
    chk1("blk0_wr_hi", mem_wr, 1'b1);
    chk1("blk0_ready", byte_ready, 1'b0);
    @(negedge clk);
    chk1("blk0_done_lo", done, 1'b0);
    chk1("blk0_idle", busy, 1'b0);
    compare_writes("blk0");

    // Block pairing: base 0x123 aligns to 0x120, two blocks
    clear_mon();
    push_block(11'h120, 8'h40);
    push_block(11'h128, 8'h60);
    do_start(11'h123, 9'd2);
    send_stream(8'h40, 64, 1'b0);
    wait_done(50);
    repeat (2) @(negedge clk);
    compare_writes("pair");
    chk("pair_done_cnt", 64'(done_cnt), 64'd1);
    chk("pair_done_lat", 64'(done_cyc - last_wr_cyc), 64'd1);
    chk("pair_err_cnt", 64'(err_cnt), 64'd0);

    // Wrap-around past 0x7FF
    clear_mon();
    push_block(11'h7F8, 8'h80);
    push_block(11'h000, 8'hA0);
    do_start(11'h7F8, 9'd2);
    in_sess = 1'b1;
    send_stream(8'h80, 64, 1'b0);
    wait_done(50);
    in_sess = 1'b0;
    repeat (2) @(negedge clk);
    compare_writes("wrap");
    chk("wrap_busy_gap", 64'(busy_gap), 64'd0);

    // Back-pressure and random gaps, three blocks
    clear_mon();
    push_block(11'h300, 8'hF0);
    push_block(11'h308, 9'h110);
    push_block(11'h310, 9'h130);
    do_start(11'h300, 9'd3);
    send_stream(8'hF0, 96, 1'b1);
    wait_done(50);
    repeat (2) @(negedge clk);
    compare_writes("bp");
    chk("bp_stall", 64'(stall_cnt), 64'd12);
    chk("bp_overlap", 64'(overlap_cnt), 64'd0);

    // Zero-length session
    clear_mon();
    do_start(11'h050, 9'd0);
    chk1("zero_done", done, 1'b1);
    chk1("zero_busy", busy, 1'b1);
    chk1("zero_ready", byte_ready, 1'b0);
    @(negedge clk);
    chk1("zero_done_lo", done, 1'b0);
    chk1("zero_idle", busy, 1'b0);
    repeat (2) @(negedge clk);
    chk("zero_nowr", 64'(got_q.size()), 64'h0);

    // Illegal start during WRITE
    clear_mon();
    push_block(11'h400, 0);
    do_start(11'h400, 9'd1);
    send_stream(0, 32, 1'b0);
    chk1("ill_in_write", mem_wr, 1'b0);
    start = 1'b1;
    base_addr = 11'h7F0;
    num_blocks = 9'd5;
    @(negedge clk);
    start = 1'b0;
    chk1("ill_err", error, 1'b1);
    @(negedge clk);
    chk1("ill_err_lo", error, 1'b0);
    wait_done(50);
    repeat (2) @(negedge clk);
    compare_writes("ill");
    chk("ill_err_cnt", 64'(err_cnt), 64'd1);
    chk("ill_done_cnt", 64'(done_cnt), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
